// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard-control bundle: hazard operands from ID/EX/MEM and the
// stall/flush controls returned to the pipeline registers.
interface hazard_ctrl_if;
  logic [4:0]  ID_rs;
  logic [4:0]  ID_rt;
  logic        ID_UsesRt;
  logic [2:0]  ID_PCsrc;
  logic        IDEX_MemRd;
  logic        IDEX_RegWr;
  logic [4:0]  IDEX_rdes;
  logic        EXMEM_MemRd;
  logic [4:0]  EXMEM_rdes;
  logic        EX_BranchTaken;
  logic        PC_Wr;
  logic        IFID_Wr;
  logic        IFID_Flush;
  logic        IDEX_Flush;
  logic        ctrl_state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  // The pipeline drives the hazard operands and consumes the controls.
  modport master (
    output ID_rs, ID_rt, ID_UsesRt, ID_PCsrc,
    output IDEX_MemRd, IDEX_RegWr, IDEX_rdes,
    output EXMEM_MemRd, EXMEM_rdes, EX_BranchTaken,
    input  PC_Wr, IFID_Wr, IFID_Flush, IDEX_Flush,
    input  ctrl_state, stall_cnt, flush_cnt
  );

  modport slave (
    input  ID_rs, ID_rt, ID_UsesRt, ID_PCsrc,
    input  IDEX_MemRd, IDEX_RegWr, IDEX_rdes,
    input  EXMEM_MemRd, EXMEM_rdes, EX_BranchTaken,
    output PC_Wr, IFID_Wr, IFID_Flush, IDEX_Flush,
    output ctrl_state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage MIPS-style pipeline: load-use and
// jr-behind-load stalls, taken-branch flushes, and saturating event counters.
module hazard_ctrl (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [2:0]  PC_J  = 3'b010;
  localparam logic [2:0]  PC_JR = 3'b011;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_t      state_q, state_d;
  logic [1:0]  remain_q, remain_d;
  logic [15:0] stall_cnt_q, flush_cnt_q;

  logic        is_jr, is_jump;
  logic        lu_hz, jr2_hz, jr1_hz;
  logic [1:0]  need;

  logic        pc_wr, ifid_wr, ifid_flush, idex_flush;
  logic        stall_cycle, flush_cycle;

  // ALU results are forwarded, so a register write in EX never forces a stall.
  logic        unused_regwr;
  assign unused_regwr = bus.IDEX_RegWr;

  // Hazard detection; register 0 is hard-wired and never a real dependency.
  always_comb begin
    is_jr   = (bus.ID_PCsrc == PC_JR);
    is_jump = (bus.ID_PCsrc == PC_J) || is_jr;

    lu_hz  = bus.IDEX_MemRd && (bus.IDEX_rdes != 5'd0) &&
             ((bus.IDEX_rdes == bus.ID_rs) ||
              (bus.ID_UsesRt && (bus.IDEX_rdes == bus.ID_rt)));
    jr2_hz = is_jr && bus.IDEX_MemRd && (bus.IDEX_rdes != 5'd0) &&
             (bus.IDEX_rdes == bus.ID_rs);
    jr1_hz = is_jr && bus.EXMEM_MemRd && (bus.EXMEM_rdes != 5'd0) &&
             (bus.EXMEM_rdes == bus.ID_rs) && !jr2_hz;

    if (jr2_hz)               need = 2'd2;
    else if (jr1_hz || lu_hz) need = 2'd1;
    else                      need = 2'd0;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the if/else chain can leave a value unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    pc_wr       = 1'b1;
    ifid_wr     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    stall_cycle = 1'b0;

    if (reset) begin
      pc_wr      = 1'b0;
      ifid_wr    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = RUN;
      remain_d   = 2'd0;
    end else if (bus.EX_BranchTaken) begin
      // A taken branch squashes everything younger, including any hazard.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = RUN;
      remain_d   = 2'd0;
    end else if (state_q == STALL) begin
      stall_cycle = 1'b1;
      if (remain_q <= 2'd1) begin
        state_d  = RUN;
        remain_d = 2'd0;
      end else begin
        remain_d = remain_q - 2'd1;
      end
    end else if (need != 2'd0) begin
      stall_cycle = 1'b1;
      if (need == 2'd2) begin
        state_d  = STALL;
        remain_d = 2'd1;
      end
    end else begin
      ifid_flush = is_jump;
    end

    if (stall_cycle) begin
      pc_wr      = 1'b0;
      ifid_wr    = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b1;
    end

    flush_cycle = !reset && !stall_cycle && (ifid_flush || idex_flush);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      remain_q    <= 2'd0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      if (stall_cycle && (stall_cnt_q != CNT_MAX))
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_cycle && (flush_cnt_q != CNT_MAX))
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign bus.PC_Wr      = pc_wr;
  assign bus.IFID_Wr    = ifid_wr;
  assign bus.IFID_Flush = ifid_flush;
  assign bus.IDEX_Flush = idex_flush;
  assign bus.ctrl_state = (state_q == STALL);
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;

endmodule
